led_to_bcd: RTL and testbench
=============================

LED_TO_BCD -- requirements
Module: led_to_bcd

Interface
REQ-001 SHALL have parameter: STABLE_CNT, default 3, consecutive matching samples needed to commit a pattern (legal 1..15).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: sample_en  input  1  qualifies LED sampling on the current edge.
REQ-005 SHALL have port: LED  input  7  segment lines {A,B,C,D,E,F,G}, LED[6]=A, LED[0]=G.
REQ-006 SHALL have port: LED_TYPE  input  1  0 = common anode (segment on when low), 1 = common cathode (segment on when high).
REQ-007 SHALL have port: number  output  4  decoded hex digit 0x0..0xF.
REQ-008 SHALL have port: valid  output  1  number holds a new, not yet accepted digit.
REQ-009 SHALL have port: ready  input  1  consumer accepts number on an edge where valid=1.
REQ-010 SHALL have port: blank  output  1  last qualified pattern was all segments off.
REQ-011 SHALL have port: err  output  1  one-cycle pulse, a qualified pattern matched no table entry.

Function
REQ-012 SHALL normalise LED to active-high as seg = LED_TYPE ? LED : ~LED before all comparisons.
REQ-013 SHALL decode seg (ABCDEFG) as: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47; 00 = blank; anything else = invalid.
REQ-014 SHALL implement FSM states IDLE (no candidate), QUAL (counting matches), HOLD (valid=1 awaiting ready).
REQ-015 SHALL, on each sample_en edge, compare seg with the stored candidate: equal -> match count +1 (saturating at STABLE_CNT); different -> candidate=seg, count=1; edges without sample_en leave candidate and count unchanged.
REQ-016 SHALL qualify a candidate on the edge its count reaches STABLE_CNT (STABLE_CNT=1: the first sample qualifies).
REQ-017 SHALL, on qualification of a valid digit differing from the last committed pattern, load number and set valid on that same edge (latency: valid visible after the STABLE_CNT-th matching sample edge); equal to last committed -> no new valid.
REQ-018 SHALL, on qualification of blank, set blank=1, not assert valid, and clear the last-committed record so the next digit, even if repeated, commits.
REQ-019 SHALL clear blank on the next digit commit.
REQ-020 SHALL, on qualification of an invalid pattern, pulse err for exactly one cycle, leave number/valid unchanged; a continuously held invalid pattern pulses err once only.
REQ-021 SHALL hold number stable and valid=1 in HOLD until an edge with ready=1; valid then drops unless a commit occurs on the same edge (back-to-back: valid stays 1, number updates).
REQ-022 SHALL, if a digit qualifies while valid=1 and ready=0, keep it pending (count saturated) and commit it on the first edge ready=1; a candidate change before then discards the pending digit.
REQ-023 SHALL treat a LED_TYPE change as an ordinary seg change (restarts qualification).

Reset
REQ-024 SHALL, while rst_n=0, force number=0, valid=0, blank=0, err=0, count=0, candidate and last-committed record cleared, FSM=IDLE.
REQ-025 SHALL, on reset assertion mid-HOLD or mid-QUAL, discard the digit without any ready handshake.
REQ-026 SHALL release from reset synchronously to clk with the first sample_en edge after release counted as sample 1.

Configuration
REQ-027 SHALL, with macro LED_TO_BCD_ERRCNT_EN defined, add output err_count (8 bits, reset 0) incrementing once per err pulse, saturating at 255, never wrapping.
REQ-028 SHALL, without LED_TO_BCD_ERRCNT_EN, have no err_count port or counter; all other behaviour identical.

Verification
REQ-029 SHALL cover: LED_TYPE=1, LED=0x6D held, sample_en=1, STABLE_CNT=3 -> valid=1, number=2 after third edge; ready=1 next edge -> valid=0; held further -> no new valid.
REQ-030 SHALL cover: LED_TYPE=0, LED=~0x4E=0x31 held 3 samples -> number=0xC, valid=1; same after LED_TYPE=1 with LED=0x4E.
REQ-031 SHALL cover: 0x30 x2 then 0x7F x3 -> only number=8 commits; glitch never reaches valid.
REQ-032 SHALL cover: ready=0, digit 5 committed, then 0x70 held 3 samples -> number stays 5; ready=1 -> next edge valid=1, number=7.
REQ-033 SHALL cover: LED=0x01 held 10 samples -> err exactly one pulse (err_count=1 with macro); then 0x00 x3 -> blank=1; then 0x30 x3 twice separated by blank -> two commits of 1.
REQ-034 SHALL cover: rst_n low during HOLD -> valid, number, blank cleared immediately, asynchronous to clk.

Source files
------------

// File: rtl/led_to_bcd_if.sv
// Seven-segment sample in, hex digit out with valid/ready; err_count exists only with LED_TO_BCD_ERRCNT_EN.
interface led_to_bcd_if;
    logic       sample_en;
    logic [6:0] LED;
    logic       LED_TYPE;
    logic [3:0] number;
    logic       valid;
    logic       ready;
    logic       blank;
    logic       err;
`ifdef LED_TO_BCD_ERRCNT_EN
    logic [7:0] err_count;
`endif

    modport master (
        output sample_en, LED, LED_TYPE, ready,
        input  number, valid, blank, err
`ifdef LED_TO_BCD_ERRCNT_EN
        , input err_count
`endif
    );

    modport slave (
        input  sample_en, LED, LED_TYPE, ready,
        output number, valid, blank, err
`ifdef LED_TO_BCD_ERRCNT_EN
        , output err_count
`endif
    );
endinterface

// File: rtl/led_to_bcd.sv
// Debounced 7-segment to hex decoder: valid rises on the STABLE_CNT-th matching sample edge.
// number is held until ready; a digit qualifying while unaccepted waits; LED_TO_BCD_ERRCNT_EN adds err_count.
module led_to_bcd #(
    parameter int STABLE_CNT = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    led_to_bcd_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

    localparam logic [3:0] SC = 4'(STABLE_CNT);

    state_t     state_q, state_nx;
    logic [6:0] cand_q, cand_nx, last_q, last_nx, seg;
    logic [3:0] cnt_q, cnt_nx, num_q, num_nx, dig;
    logic       pend_q, pend_nx, blank_q, blank_nx, err_q, err_nx;
    logic       new_cand, qual, dig_ok, do_commit;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h7E: decode = {1'b1, 4'h0};
            7'h30: decode = {1'b1, 4'h1};
            7'h6D: decode = {1'b1, 4'h2};
            7'h79: decode = {1'b1, 4'h3};
            7'h33: decode = {1'b1, 4'h4};
            7'h5B: decode = {1'b1, 4'h5};
            7'h5F: decode = {1'b1, 4'h6};
            7'h70: decode = {1'b1, 4'h7};
            7'h7F: decode = {1'b1, 4'h8};
            7'h7B: decode = {1'b1, 4'h9};
            7'h77: decode = {1'b1, 4'hA};
            7'h1F: decode = {1'b1, 4'hB};
            7'h4E: decode = {1'b1, 4'hC};
            7'h3D: decode = {1'b1, 4'hD};
            7'h4F: decode = {1'b1, 4'hE};
            7'h47: decode = {1'b1, 4'hF};
            default: decode = 5'h00;
        endcase
    endfunction

    always_comb begin
        state_nx  = state_q;
        cand_nx   = cand_q;
        cnt_nx    = cnt_q;
        last_nx   = last_q;
        num_nx    = num_q;
        pend_nx   = pend_q;
        blank_nx  = blank_q;
        err_nx    = 1'b0;
        new_cand  = 1'b0;
        qual      = 1'b0;
        do_commit = 1'b0;
        seg       = bus.LED_TYPE ? bus.LED : ~bus.LED;

        if (bus.sample_en) begin
            if ((seg == cand_q) && (cnt_q != 4'd0)) begin
                cnt_nx = (cnt_q >= SC) ? SC : cnt_q + 4'd1;
            end else begin
                new_cand = 1'b1;
                cand_nx  = seg;
                cnt_nx   = 4'd1;
                pend_nx  = 1'b0;
            end
            // Qualify only on the edge the count arrives at STABLE_CNT, never while saturated
            qual = (cnt_nx == SC) && (new_cand || (cnt_q != SC));
        end

        {dig_ok, dig} = decode(cand_nx);

        if (qual && dig_ok && (cand_nx != last_q)) begin
            if ((state_q != HOLD) || bus.ready)
                do_commit = 1'b1;
            else
                pend_nx = 1'b1;
        end
        if (pend_q && !new_cand && (state_q == HOLD) && bus.ready)
            do_commit = 1'b1;

        if (qual && (cand_nx == 7'h00)) begin
            blank_nx = 1'b1;
            last_nx  = 7'h00;
        end
        if (qual && !dig_ok && (cand_nx != 7'h00))
            err_nx = 1'b1;

        if (do_commit) begin
            num_nx   = dig;
            last_nx  = cand_nx;
            blank_nx = 1'b0;
            pend_nx  = 1'b0;
            state_nx = HOLD;
        end else if (state_q == HOLD) begin
            if (bus.ready)
                state_nx = QUAL;
        end else if (bus.sample_en) begin
            state_nx = QUAL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= 7'h00;
            cnt_q   <= 4'd0;
            last_q  <= 7'h00;
            num_q   <= 4'h0;
            pend_q  <= 1'b0;
            blank_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            cand_q  <= cand_nx;
            cnt_q   <= cnt_nx;
            last_q  <= last_nx;
            num_q   <= num_nx;
            pend_q  <= pend_nx;
            blank_q <= blank_nx;
            err_q   <= err_nx;
        end
    end

    assign bus.number = num_q;
    assign bus.valid  = (state_q == HOLD);
    assign bus.blank  = blank_q;
    assign bus.err    = err_q;

`ifdef LED_TO_BCD_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt_q <= 8'd0;
        else if (err_nx && (err_cnt_q != 8'hFF))
            err_cnt_q <= err_cnt_q + 8'd1;
    end

    assign bus.err_count = err_cnt_q;
`endif
endmodule

// File: tb/tb_led_to_bcd.sv
// Directed-vector bench for led_to_bcd with STABLE_CNT=3.
module tb_led_to_bcd;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;
    int   errs;

    led_to_bcd_if bus ();

    led_to_bcd #(.STABLE_CNT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [6:0] v, input int n);
        bus.LED       = v;
        bus.sample_en = 1'b1;
        repeat (n) step();
    endtask

    task automatic accept(input string tag);
        bus.sample_en = 1'b0;
        bus.ready     = 1'b1;
        step();
        bus.ready     = 1'b0;
        check(tag, 32'(bus.valid), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        errs  = 0;
        rst_n = 1'b0;
        bus.sample_en = 1'b0;
        bus.LED       = 7'h00;
        bus.LED_TYPE  = 1'b1;
        bus.ready     = 1'b0;
        repeat (2) step();
        check("rst_valid",  32'(bus.valid),  32'd0);
        check("rst_number", 32'(bus.number), 32'd0);
        check("rst_blank",  32'(bus.blank),  32'd0);
        check("rst_err",    32'(bus.err),    32'd0);
        rst_n = 1'b1;

        // CC digit 2 after three samples, then accepted and held with no new valid
        samp(7'h6D, 2);
        check("d2_early", 32'(bus.valid), 32'd0);
        step();
        check("d2_valid",  32'(bus.valid),  32'd1);
        check("d2_number", 32'(bus.number), 32'd2);
        bus.ready = 1'b1;
        step();
        check("d2_acc", 32'(bus.valid), 32'd0);
        repeat (3) step();
        check("d2_held", 32'(bus.valid), 32'd0);
        bus.ready = 1'b0;

        // Common anode C, then a 1, then common cathode C
        bus.LED_TYPE = 1'b0;
        samp(7'h31, 3);
        check("ca_c_valid",  32'(bus.valid),  32'd1);
        check("ca_c_number", 32'(bus.number), 32'hC);
        accept("ca_c_acc");
        bus.LED_TYPE = 1'b1;
        samp(7'h30, 3);
        check("cc_1_number", 32'(bus.number), 32'd1);
        accept("cc_1_acc");
        samp(7'h4E, 3);
        check("cc_c_valid",  32'(bus.valid),  32'd1);
        check("cc_c_number", 32'(bus.number), 32'hC);
        accept("cc_c_acc");

        // Two-sample glitch of 1 must not commit; 8 does
        samp(7'h30, 2);
        check("glitch", 32'(bus.valid), 32'd0);
        samp(7'h7F, 2);
        check("d8_early", 32'(bus.valid), 32'd0);
        step();
        check("d8_valid",  32'(bus.valid),  32'd1);
        check("d8_number", 32'(bus.number), 32'd8);
        accept("d8_acc");

        // Pending digit behind an unaccepted one
        samp(7'h5B, 3);
        check("d5_number", 32'(bus.number), 32'd5);
        samp(7'h70, 3);
        check("pend_number", 32'(bus.number), 32'd5);
        check("pend_valid",  32'(bus.valid),  32'd1);
        bus.sample_en = 1'b0;
        bus.ready     = 1'b1;
        step();
        bus.ready     = 1'b0;
        check("b2b_valid",  32'(bus.valid),  32'd1);
        check("b2b_number", 32'(bus.number), 32'd7);
        accept("d7_acc");

        // Invalid pattern held: one err pulse on the third sample
        bus.LED       = 7'h01;
        bus.sample_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            errs += int'(bus.err);
            if (i == 2) check("err_pulse", 32'(bus.err), 32'd1);
        end
        check("err_once",   32'(errs),        32'd1);
        check("err_number", 32'(bus.number), 32'd7);
`ifdef LED_TO_BCD_ERRCNT_EN
        check("err_count", 32'(bus.err_count), 32'd1);
`endif
        samp(7'h00, 3);
        check("blank_set",   32'(bus.blank), 32'd1);
        check("blank_valid", 32'(bus.valid), 32'd0);
        samp(7'h30, 3);
        check("r1_valid",  32'(bus.valid),  32'd1);
        check("r1_number", 32'(bus.number), 32'd1);
        check("blank_clr", 32'(bus.blank),  32'd0);
        accept("r1_acc");
        samp(7'h00, 3);
        check("blank_set2", 32'(bus.blank), 32'd1);
        samp(7'h30, 3);
        check("r2_valid",  32'(bus.valid),  32'd1);
        check("r2_number", 32'(bus.number), 32'd1);
        accept("r2_acc");

        // Asynchronous reset while holding a digit with blank set
        samp(7'h7B, 3);
        check("d9_number", 32'(bus.number), 32'd9);
        samp(7'h00, 3);
        check("hold_blank", 32'(bus.blank), 32'd1);
        check("hold_valid", 32'(bus.valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid",  32'(bus.valid),  32'd0);
        check("arst_number", 32'(bus.number), 32'd0);
        check("arst_blank",  32'(bus.blank),  32'd0);
        step();
        rst_n = 1'b1;
        samp(7'h7B, 3);
        check("post_valid",  32'(bus.valid),  32'd1);
        check("post_number", 32'(bus.number), 32'd9);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
